// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
// Shared widths, exception flag indices, exception codes and the decoded
// layout of the memory-to-writeback bus for the write-back stage.
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int EXC_NUM           = 6;
    localparam int MS_TO_WS_BUS_WD   = 1 + 14 + 32 + 32 + 1 + EXC_NUM + 1 + 5 + 32 + 32;
    localparam int WS_TO_RF_BUS_WD   = 38;
    localparam int WS_FWD_BLK_BUS_WD = 38;
    localparam int WS_CSR_BLK_BUS_WD = 16;

    // bit positions inside exc_flgs
    localparam int EXC_FLG_INT  = 0;
    localparam int EXC_FLG_ADEF = 1;
    localparam int EXC_FLG_INE  = 2;
    localparam int EXC_FLG_SYS  = 3;
    localparam int EXC_FLG_BRK  = 4;
    localparam int EXC_FLG_ALE  = 5;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    // memory-stage bus, MSB first
    typedef struct packed {
        logic                csr_we;
        logic [13:0]         csr_wnum;
        logic [31:0]         csr_wmask;
        logic [31:0]         csr_wdata;
        logic                inst_ertn;
        logic [EXC_NUM-1:0]  exc_flgs;
        logic                gr_we;
        logic [4:0]          dest;
        logic [31:0]         final_result;
        logic [31:0]         pc;
    } ms_to_ws_t;

endpackage

// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// Memory-stage to write-back-stage handshake.
//   ms_to_ws_valid : memory stage presents an instruction
//   ms_to_ws_bus   : instruction payload (layout in wb_stage_pkg::ms_to_ws_t)
//   ws_allowin     : write-back stage can accept this cycle
// master = memory stage, slave = write-back stage.
// ---------------------------------------------------------------------------
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       ws_allowin;

    modport master (
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        output ws_allowin
    );

endinterface

// File: rtl/wb_stage_exc_encode.sv
// ---------------------------------------------------------------------------
// wb_exc_encode
// Combinational priority encoder for committing exceptions.
//   exc_flgs     in  : exception flags of the write-back instruction
//   pc           in  : instruction PC (bad address for ADEF)
//   final_result in  : result / address (bad address for ALE)
//   ecode        out : exception code, INT > ADEF > INE > SYS > BRK > ALE
//   esubcode     out : exception sub-code (always zero here)
//   badv         out : bad virtual address, zero when not address-related
// ---------------------------------------------------------------------------
module wb_exc_encode
    import wb_stage_pkg::*;
(
    input  logic [EXC_NUM-1:0] exc_flgs,
    input  logic [31:0]        pc,
    input  logic [31:0]        final_result,
    output logic [5:0]         ecode,
    output logic [8:0]         esubcode,
    output logic [31:0]        badv
);

    always_comb begin
        ecode    = ECODE_INT;
        esubcode = ESUBCODE_NONE;
        badv     = 32'h0;
        if (exc_flgs[EXC_FLG_INT]) begin
            ecode = ECODE_INT;
        end else if (exc_flgs[EXC_FLG_ADEF]) begin
            ecode = ECODE_ADEF;
            badv  = pc;
        end else if (exc_flgs[EXC_FLG_INE]) begin
            ecode = ECODE_INE;
        end else if (exc_flgs[EXC_FLG_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc_flgs[EXC_FLG_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc_flgs[EXC_FLG_ALE]) begin
            ecode = ECODE_ALE;
            badv  = final_result;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage: registers one instruction from the memory stage and
// commits its register-file and CSR writes, raises exception / ertn flush,
// counts retired instructions and feeds forwarding / CSR-hazard info to decode.
//
// Ports
//   clk, resetn        : clock, asynchronous active-low reset
//   ms_if (slave)      : ms_to_ws_valid / ms_to_ws_bus in, ws_allowin out
//   ws_to_rf_bus       : {rf_we, rf_waddr, rf_wdata}
//   ws_fwd_blk_bus     : {gr_we & ws_valid, dest, final_result}
//   ws_csr_blk_bus     : {csr_we & ws_valid, inst_ertn & ws_valid, csr_wnum}
//   csr_we/wnum/wmask/wdata : CSR file write port
//   wb_exc, wb_ertn    : flush requests, one cycle per committing instruction
//   wb_ecode, wb_esubcode, wb_pc, wb_badv : exception information
//   ws_retire_cnt      : 64-bit retired-instruction counter
//   debug_wb_*         : trace ports, present only with WS_DEBUG_TRACE_EN
//
// Build option: define WS_DEBUG_TRACE_EN to add the debug_wb_* trace ports.
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    wb_stage_if.slave                    ms_if,
    output logic [WS_TO_RF_BUS_WD-1:0]   ws_to_rf_bus,
    output logic [WS_FWD_BLK_BUS_WD-1:0] ws_fwd_blk_bus,
    output logic [WS_CSR_BLK_BUS_WD-1:0] ws_csr_blk_bus,
    output logic                         csr_we,
    output logic [13:0]                  csr_wnum,
    output logic [31:0]                  csr_wmask,
    output logic [31:0]                  csr_wdata,
    output logic                         wb_exc,
    output logic                         wb_ertn,
    output logic [5:0]                   wb_ecode,
    output logic [8:0]                   wb_esubcode,
    output logic [31:0]                  wb_pc,
    output logic [31:0]                  wb_badv,
    output logic [63:0]                  ws_retire_cnt
`ifdef WS_DEBUG_TRACE_EN
    ,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata
`endif
);

    logic      ws_valid;
    logic      ws_ready_go;
    logic      ws_allowin;
    ms_to_ws_t ws_bus_r;
    logic      wb_flush;
    logic      rf_we;

    // the stage never stalls; allowin is kept in its general form so a
    // future stall condition only has to touch ws_ready_go
    assign ws_ready_go      = 1'b1;
    assign ws_allowin       = !ws_valid || ws_ready_go;
    assign ms_if.ws_allowin = ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_bus_r <= '0;
        end else if (ms_if.ms_to_ws_valid && ws_allowin) begin
            ws_bus_r <= ms_to_ws_t'(ms_if.ms_to_ws_bus);
        end
    end

    // a flush kills both the committing instruction and anything arriving
    // in the same cycle, since the incoming one is younger
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (wb_flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_if.ms_to_ws_valid;
        end
    end

    // ertn retires, excepting instructions do not
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_retire_cnt <= 64'h0;
        end else if (ws_valid && !wb_exc) begin
            ws_retire_cnt <= ws_retire_cnt + 64'h1;
        end
    end

    assign wb_exc   = ws_valid && (|ws_bus_r.exc_flgs);
    assign wb_ertn  = ws_valid && ws_bus_r.inst_ertn && !wb_exc;
    assign wb_flush = wb_exc || wb_ertn;

    assign rf_we     = ws_valid && ws_bus_r.gr_we && !wb_exc;
    assign csr_we    = ws_valid && ws_bus_r.csr_we && !wb_exc && !ws_bus_r.inst_ertn;
    assign csr_wnum  = ws_bus_r.csr_wnum;
    assign csr_wmask = ws_bus_r.csr_wmask;
    assign csr_wdata = ws_bus_r.csr_wdata;

    assign ws_to_rf_bus   = {rf_we, ws_bus_r.dest, ws_bus_r.final_result};
    assign ws_fwd_blk_bus = {ws_bus_r.gr_we && ws_valid, ws_bus_r.dest, ws_bus_r.final_result};
    assign ws_csr_blk_bus = {ws_bus_r.csr_we && ws_valid, ws_bus_r.inst_ertn && ws_valid,
                             ws_bus_r.csr_wnum};

    assign wb_pc = ws_bus_r.pc;

    wb_exc_encode u_exc_encode (
        .exc_flgs     (ws_bus_r.exc_flgs),
        .pc           (ws_bus_r.pc),
        .final_result (ws_bus_r.final_result),
        .ecode        (wb_ecode),
        .esubcode     (wb_esubcode),
        .badv         (wb_badv)
    );

`ifdef WS_DEBUG_TRACE_EN
    assign debug_wb_pc       = ws_bus_r.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_bus_r.dest;
    assign debug_wb_rf_wdata = ws_bus_r.final_result;
`endif

endmodule
